// File: rtl/dm_load_store_unit.sv
// Byte/half/word load-store front end for a word-addressed data memory; sub-word stores use read-modify-write.
// Optional DM_LSU_MISALIGN_TRAP_EN: misaligned requests complete immediately with err instead of being force-aligned.
module dm_load_store_unit #(
    parameter int DM_AW = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_signed,
    input  logic [DM_AW+1:0] req_addr,
    input  logic [31:0]      req_wdata,
    output logic             ready,
    output logic             done,
    output logic             err,
    output logic [31:0]      rdata,
    output logic [DM_AW-1:0] dm_addr,
    output logic [31:0]      dm_wd,
    output logic             dm_we,
    input  logic [31:0]      dm_rd
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t           state_q, state_d;
    logic             we_q, we_d;
    logic [1:0]       size_q, size_d;
    logic             signed_q, signed_d;
    logic [DM_AW+1:0] addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rbuf_q, rbuf_d;
    logic [31:0]      rdata_q, rdata_d;

    logic [DM_AW+1:0] addr_in;
    logic [31:0]      load_ext;
    logic [31:0]      merged;
    logic [3:0]       byte_en;
    logic [31:0]      lane_wd;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;

`ifdef DM_LSU_MISALIGN_TRAP_EN
    logic err_q, err_d;
    logic misaligned;

    always_comb begin
        misaligned = (req_size == 2'b01 && req_addr[0]) || (req_size[1] && req_addr[1:0] != 2'b00);
        addr_in    = req_addr;
    end

    assign err = (state_q == RESP) & err_q;
`else
    always_comb begin
        addr_in = req_addr;
        case (req_size)
            2'b00:   addr_in = req_addr;
            2'b01:   addr_in[0] = 1'b0;
            default: addr_in[1:0] = 2'b00;
        endcase
    end

    assign err = 1'b0;
`endif

    // Lane extraction works straight off dm_rd so rdata is ready at the RD->RESP edge.
    always_comb begin
        byte_sel = dm_rd[{addr_q[1:0], 3'b000} +: 8];
        half_sel = addr_q[1] ? dm_rd[31:16] : dm_rd[15:0];
        case (size_q)
            2'b00:   load_ext = {{24{signed_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_ext = {{16{signed_q & half_sel[15]}}, half_sel};
            default: load_ext = dm_rd;
        endcase
    end

    always_comb begin
        case (size_q)
            2'b00: begin
                byte_en = 4'b0001 << addr_q[1:0];
                lane_wd = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
                lane_wd = {2{wdata_q[15:0]}};
            end
            default: begin
                byte_en = 4'b1111;
                lane_wd = wdata_q;
            end
        endcase
        merged = rbuf_q;
        for (int unsigned i = 0; i < 4; i++) begin
            if (byte_en[i]) merged[8*i +: 8] = lane_wd[8*i +: 8];
        end
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        size_d   = size_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rbuf_d   = rbuf_q;
        rdata_d  = rdata_q;
`ifdef DM_LSU_MISALIGN_TRAP_EN
        err_d    = err_q;
`endif
        ready    = 1'b0;
        done     = 1'b0;
        dm_we    = 1'b0;
        dm_wd    = '0;
        dm_addr  = '0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (req) begin
                    we_d     = req_we;
                    size_d   = req_size;
                    signed_d = req_signed;
                    addr_d   = addr_in;
                    wdata_d  = req_wdata;
                    state_d  = RD;
`ifdef DM_LSU_MISALIGN_TRAP_EN
                    err_d    = misaligned;
                    if (misaligned) state_d = RESP;
`endif
                end
            end
            RD: begin
                dm_addr = addr_q[DM_AW+1:2];
                rbuf_d  = dm_rd;
                if (we_q) begin
                    state_d = WR;
                end else begin
                    rdata_d = load_ext;
                    state_d = RESP;
                end
            end
            WR: begin
                dm_addr = addr_q[DM_AW+1:2];
                dm_we   = ~rst;
                dm_wd   = merged;
                state_d = RESP;
            end
            RESP: begin
                dm_addr = addr_q[DM_AW+1:2];
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            size_q   <= '0;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rbuf_q   <= '0;
            rdata_q  <= '0;
`ifdef DM_LSU_MISALIGN_TRAP_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rbuf_q   <= rbuf_d;
            rdata_q  <= rdata_d;
`ifdef DM_LSU_MISALIGN_TRAP_EN
            err_q    <= err_d;
`endif
        end
    end

    assign rdata = rdata_q;

endmodule

// File: tb/tb_dm_load_store_unit.sv
// Directed + random bench for dm_load_store_unit with a behavioural 32x32 data memory and an expectation queue.
module tb_dm_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [6:0]  req_addr;
    logic [31:0] req_wdata;
    logic        ready;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [4:0]  dm_addr;
    logic [31:0] dm_wd;
    logic        dm_we;
    logic [31:0] dm_rd;

    dm_load_store_unit #(.DM_AW(5)) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .ready(ready), .done(done), .err(err), .rdata(rdata),
        .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_we(dm_we), .dm_rd(dm_rd)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [32];
    logic        mem_init;
    logic [31:0] ref_mem [32];

    function automatic logic [31:0] pat(input int i);
        return 32'h8C3A_0000 + 32'(i) * 32'h0001_0203;
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= pat(i);
        end else if (dm_we) begin
            mem[dm_addr] <= dm_wd;
        end
    end
    assign dm_rd = mem[dm_addr];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          wes;
        logic [31:0] wd;
        logic [4:0]  waddr;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_rd;
    logic [31:0] last_wd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] ld(input logic [31:0] w, input logic [1:0] sz, input logic sg, input logic [6:0] a);
        int idx;
        logic [7:0]  b;
        logic [15:0] h;
        idx = int'(a[1:0]);
        b = w[idx*8 +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        if (sz == 2'b00) return sg ? {{24{b[7]}}, b} : {24'h0, b};
        if (sz == 2'b01) return sg ? {{16{h[15]}}, h} : {16'h0, h};
        return w;
    endfunction

    function automatic logic [31:0] st(input logic [31:0] w, input logic [1:0] sz, input logic [6:0] a, input logic [31:0] d);
        logic [31:0] r;
        int idx;
        r = w;
        idx = int'(a[1:0]);
        if (sz == 2'b00) r[idx*8 +: 8] = d[7:0];
        else if (sz == 2'b01) begin
            if (a[1]) r[31:16] = d[15:0];
            else      r[15:0]  = d[15:0];
        end else r = d;
        return r;
    endfunction

    task automatic txn(input string tag, input logic we, input logic [1:0] sz, input logic sg,
                       input logic [6:0] a, input logic [31:0] wd, input logic hold);
        exp_t        e;
        exp_t        g;
        logic        mis;
        logic        trap;
        int          widx;
        int          k;
        int          lat_o;
        int          wes_o;
        int          dones;
        logic        got;
        logic        err_o;
        logic        stray;
        logic        extra;
        logic [31:0] rd_o;
        logic [4:0]  wa_o;

        mis  = (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
        trap = 1'b0;
`ifdef DM_LSU_MISALIGN_TRAP_EN
        trap = mis;
`endif
        widx = int'(a[6:2]);
        e.wd = '0;
        e.waddr = '0;
        if (trap) begin
            e.lat = 1; e.err = 1'b1; e.wes = 0;
        end else begin
            e.err = 1'b0;
            if (we) begin
                e.lat = 3; e.wes = 1;
                e.wd = st(ref_mem[widx], sz, a, wd);
                e.waddr = a[6:2];
                ref_mem[widx] = e.wd;
            end else begin
                e.lat = 2; e.wes = 0;
                exp_rd = ld(ref_mem[widx], sz, sg, a);
            end
        end
        e.rdata = exp_rd;
        sb.push_back(e);

        @(negedge clk);
        req = 1'b1; req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        @(posedge clk);
        got = 1'b0; k = 0; lat_o = -1; wes_o = 0; dones = 0; stray = 1'b0;
        err_o = 1'b0; rd_o = '0; wa_o = '0;
        while (!got && k < 12) begin
            @(negedge clk);
            k++;
            if (!hold && k == 1) req = 1'b0;
            if (dm_we) begin
                wes_o++;
                last_wd = dm_wd;
                wa_o = dm_addr;
            end else if (dm_wd != 32'h0) stray = 1'b1;
            if (ready && dm_addr != 5'd0) stray = 1'b1;
            if (done) begin
                got = 1'b1; dones++; lat_o = k; err_o = err; rd_o = rdata;
                req = 1'b0;
            end
        end
        @(negedge clk);
        extra = done | dm_we;

        g = sb.pop_front();
        chk({tag, ".lat"}, 32'(lat_o), 32'(g.lat));
        chk({tag, ".err"}, {31'h0, err_o}, {31'h0, g.err});
        chk({tag, ".rdata"}, rd_o, g.rdata);
        chk({tag, ".we_cycles"}, 32'(wes_o), 32'(g.wes));
        if (g.wes != 0) begin
            chk({tag, ".dm_wd"}, last_wd, g.wd);
            chk({tag, ".dm_addr"}, {27'h0, wa_o}, {27'h0, g.waddr});
        end
        chk({tag, ".idle_quiet"}, {31'h0, stray}, 32'h0);
        chk({tag, ".no_extra"}, {31'h0, extra}, 32'h0);
    endtask

    initial begin
        rst = 1'b1; mem_init = 1'b1; req = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0; exp_rd = '0; last_wd = '0;
        for (int i = 0; i < 32; i++) ref_mem[i] = pat(i);
        repeat (3) @(negedge clk);
        chk("rst.dm_we", {31'h0, dm_we}, 32'h0);
        rst = 1'b0; mem_init = 1'b0;
        chk("rst.ready", {31'h0, ready}, 32'h1);
        chk("rst.done", {31'h0, done}, 32'h0);
        chk("rst.err", {31'h0, err}, 32'h0);
        chk("rst.rdata", rdata, 32'h0);
        chk("rst.dm_addr", {27'h0, dm_addr}, 32'h0);
        chk("rst.dm_wd", dm_wd, 32'h0);

        txn("t1_sw", 1'b1, 2'b10, 1'b0, 7'h08, 32'hDEADBEEF, 1'b0);
        chk("t1.wd_lit", last_wd, 32'hDEADBEEF);
        txn("t2_sb", 1'b1, 2'b00, 1'b0, 7'h0A, 32'h0000_0055, 1'b0);
        chk("t2.wd_lit", last_wd, 32'hDE55BEEF);
        txn("t3_lbs", 1'b0, 2'b00, 1'b1, 7'h0B, 32'h0, 1'b0);
        chk("t3.lbs_lit", rdata, 32'hFFFFFFDE);
        txn("t3_lbu", 1'b0, 2'b00, 1'b0, 7'h0B, 32'h0, 1'b0);
        chk("t3.lbu_lit", rdata, 32'h000000DE);
        txn("t3_lhs", 1'b0, 2'b01, 1'b1, 7'h08, 32'h0, 1'b0);
        chk("t3.lhs_lit", rdata, 32'hFFFFBEEF);
        txn("t3_lhu_hi", 1'b0, 2'b01, 1'b0, 7'h0A, 32'h0, 1'b0);
        txn("t3_lw_sg", 1'b0, 2'b10, 1'b1, 7'h08, 32'h0, 1'b0);
        txn("t3_lb_top", 1'b0, 2'b00, 1'b1, 7'h7F, 32'h0, 1'b0);

        txn("t4_sh_hold", 1'b1, 2'b01, 1'b0, 7'h0E, 32'h1234A5A5, 1'b1);
        txn("t4_lw_chk", 1'b0, 2'b11, 1'b0, 7'h0C, 32'h0, 1'b0);

        // Reset lands on the WR cycle of a byte store to word 2.
        @(negedge clk);
        req = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 7'h08; req_wdata = 32'h11;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        chk("t5.we_before_rst", {31'h0, dm_we}, 32'h1);
        rst = 1'b1;
        #1;
        chk("t5.we_in_rst", {31'h0, dm_we}, 32'h0);
        @(negedge clk);
        chk("t5.ready", {31'h0, ready}, 32'h1);
        chk("t5.rdata", rdata, 32'h0);
        chk("t5.done", {31'h0, done}, 32'h0);
        chk("t5.mem2", mem[2], ref_mem[2]);
        rst = 1'b0;
        exp_rd = '0;
        txn("t5_lw_after", 1'b0, 2'b10, 1'b0, 7'h08, 32'h0, 1'b0);

        txn("t6_lh_mis", 1'b0, 2'b01, 1'b0, 7'h09, 32'h0, 1'b0);
        txn("t6_sw_mis", 1'b1, 2'b10, 1'b0, 7'h0D, 32'hCAFEF00D, 1'b0);
        txn("t6_lw_chk", 1'b0, 2'b10, 1'b0, 7'h0C, 32'h0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            txn("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                7'($urandom_range(0, 127)), $urandom, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
